// File: rtl/stall_controller.sv
// Pipeline hazard and multi-cycle divide stall controller for the ID stage.
// It detects load-use hazards, holds the pipeline during divides, and handles branch flushes.
module stall_controller #(
  parameter int unsigned DIV_LATENCY = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rsA,
  input  logic [4:0]  id_rsB,
  input  logic        id_uses_A,
  input  logic        id_uses_B,
  input  logic        id_is_div,
  input  logic [4:0]  exe_rd,
  input  logic        exe_wr_en,
  input  logic        exe_is_load,
  input  logic        exe_flush_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        flush_exe,
  output logic        div_start,
  output logic        div_abort,
  output logic        busy,
  output logic [15:0] stall_count
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned SC_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_hazard;

  assign load_hazard = exe_is_load && exe_wr_en && (exe_rd != 5'd0) &&
                       ((id_uses_A && (id_rsA == exe_rd)) ||
                        (id_uses_B && (id_rsB == exe_rd)));

  assign busy = (state != IDLE);

  // Control outputs. Reset forces all outputs low, and a flush overrides stalls and divide starts.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_exe = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (rst) begin
      stall_if = 1'b0;
    end else if (exe_flush_req) begin
      flush_id  = 1'b1;
      flush_exe = 1'b1;
      div_abort = (state == DIV_WAIT);
    end else begin
      case (state)
        IDLE: begin
          if (load_hazard || id_is_div) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            flush_exe = 1'b1;
            div_start = !load_hazard;
          end
        end
        DIV_WAIT: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          flush_exe = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State, countdown and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      if (stall_id && (stall_count != {SC_W{1'b1}}))
        stall_count <= stall_count + SC_W'(1);

      if (exe_flush_req) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (div_start) begin
              cnt   <= CNT_W'(DIV_LATENCY - 1);
              state <= DIV_WAIT;
            end
          end
          DIV_WAIT: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= DIV_DONE;
          end
          DIV_DONE: state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stall_controller.sv
// Scoreboard bench for stall_controller. The driver queues the expected outputs for each cycle,
// and a monitor on the falling edge pops each entry and compares it with the DUT outputs.
module tb_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rsA, id_rsB, exe_rd;
  logic        id_uses_A, id_uses_B, id_is_div, exe_wr_en, exe_is_load, exe_flush_req;
  logic        stall_if, stall_id, flush_id, flush_exe, div_start, div_abort, busy;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // Flag order: {stall_if, stall_id, flush_id, flush_exe, div_start, div_abort, busy}
  localparam logic [6:0] F_NONE   = 7'b0000000;
  localparam logic [6:0] F_STALL  = 7'b1101000;
  localparam logic [6:0] F_START  = 7'b1101100;
  localparam logic [6:0] F_WAIT   = 7'b1101001;
  localparam logic [6:0] F_DONE   = 7'b0000001;
  localparam logic [6:0] F_FLUSH  = 7'b0011000;
  localparam logic [6:0] F_FLDONE = 7'b0011001;
  localparam logic [6:0] F_ABORT  = 7'b0011011;

  typedef struct {
    string       name;
    logic [6:0]  flags;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  stall_controller #(.DIV_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .id_rsA(id_rsA), .id_rsB(id_rsB), .id_uses_A(id_uses_A), .id_uses_B(id_uses_B),
    .id_is_div(id_is_div), .exe_rd(exe_rd), .exe_wr_en(exe_wr_en), .exe_is_load(exe_is_load),
    .exe_flush_req(exe_flush_req),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_exe(flush_exe),
    .div_start(div_start), .div_abort(div_abort), .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Monitor: the outputs have settled by the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {stall_if, stall_id, flush_id, flush_exe, div_start, div_abort, busy};
      checks++;
      if (act !== e.flags || stall_count !== e.cnt) begin
        failures++;
        $display("FAIL %s: flags got=%b want=%b stall_count got=%h want=%h",
                 e.name, act, e.flags, stall_count, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [6:0] f, input logic [15:0] c);
    exp_t e;
    e.name  = nm;
    e.flags = f;
    e.cnt   = c;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    id_rsA = 5'd0; id_rsB = 5'd0; id_uses_A = 1'b0; id_uses_B = 1'b0;
    id_is_div = 1'b0; exe_rd = 5'd0; exe_wr_en = 1'b0; exe_is_load = 1'b0;
    exe_flush_req = 1'b0;
  endtask

  task automatic set_hazard_a();
    exe_is_load = 1'b1; exe_wr_en = 1'b1; exe_rd = 5'd5; id_rsA = 5'd5; id_uses_A = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick(); expect_out("reset", F_NONE, 16'd0);
    tick(); rst = 1'b0; expect_out("post_reset_idle", F_NONE, 16'd0);

    // Load-use hazard on source A
    tick(); set_hazard_a(); expect_out("load_use_a", F_STALL, 16'd0);
    tick(); idle_inputs(); expect_out("load_use_clear", F_NONE, 16'd1);
    // Writes to x0 and non-writing loads cause no hazard
    tick(); exe_is_load = 1'b1; exe_wr_en = 1'b1; exe_rd = 5'd0; id_uses_A = 1'b1;
    expect_out("rd_zero", F_NONE, 16'd1);
    tick(); idle_inputs(); exe_is_load = 1'b1; exe_rd = 5'd7; id_rsB = 5'd7; id_uses_B = 1'b1;
    expect_out("no_wr_en", F_NONE, 16'd1);
    tick(); exe_wr_en = 1'b1; expect_out("load_use_b", F_STALL, 16'd1);
    tick(); id_uses_B = 1'b0; expect_out("b_not_used", F_NONE, 16'd2);

    // Divide with latency 4 followed by a back-to-back divide
    tick(); idle_inputs(); id_is_div = 1'b1; expect_out("div_T", F_START, 16'd2);
    tick(); expect_out("div_T1", F_WAIT, 16'd3);
    tick(); expect_out("div_T2", F_WAIT, 16'd4);
    tick(); expect_out("div_T3", F_WAIT, 16'd5);
    tick(); expect_out("div_T4_done", F_DONE, 16'd6);
    tick(); expect_out("div_back2back", F_START, 16'd6);
    tick(); expect_out("div2_T1", F_WAIT, 16'd7);
    tick(); exe_flush_req = 1'b1; expect_out("flush_abort", F_ABORT, 16'd8);
    tick(); idle_inputs(); expect_out("abort_idle", F_NONE, 16'd8);

    // A load hazard defers the divide start
    tick(); set_hazard_a(); id_is_div = 1'b1; expect_out("hazard_prio", F_STALL, 16'd8);
    tick(); exe_is_load = 1'b0; expect_out("deferred_start", F_START, 16'd9);
    tick(); expect_out("def_T1", F_WAIT, 16'd10);
    tick(); expect_out("def_T2", F_WAIT, 16'd11);
    tick(); expect_out("def_T3", F_WAIT, 16'd12);
    tick(); idle_inputs(); expect_out("def_done", F_DONE, 16'd13);
    tick(); expect_out("def_idle", F_NONE, 16'd13);

    // A flush in DIV_DONE does not abort
    tick(); id_is_div = 1'b1; expect_out("div3_T", F_START, 16'd13);
    tick(); expect_out("div3_T1", F_WAIT, 16'd14);
    tick(); expect_out("div3_T2", F_WAIT, 16'd15);
    tick(); expect_out("div3_T3", F_WAIT, 16'd16);
    tick(); exe_flush_req = 1'b1; expect_out("flush_in_done", F_FLDONE, 16'd17);
    // A flush in IDLE overrides both the hazard and the divide
    tick(); set_hazard_a(); id_is_div = 1'b1; exe_flush_req = 1'b1;
    expect_out("flush_over_hazard", F_FLUSH, 16'd17);
    tick(); idle_inputs(); expect_out("flush_idle", F_NONE, 16'd17);

    // Assert reset asynchronously in the middle of DIV_WAIT
    tick(); id_is_div = 1'b1; expect_out("div4_T", F_START, 16'd17);
    tick(); expect_out("div4_T1", F_WAIT, 16'd18);
    tick(); #2; rst = 1'b1; exe_flush_req = 1'b1; expect_out("async_rst", F_NONE, 16'd0);
    tick(); set_hazard_a(); expect_out("rst_held", F_NONE, 16'd0);
    tick(); rst = 1'b0; idle_inputs(); expect_out("rst_release", F_NONE, 16'd0);
    tick(); id_is_div = 1'b1; expect_out("div5_T", F_START, 16'd0);
    tick(); expect_out("div5_T1", F_WAIT, 16'd1);
    tick(); expect_out("div5_T2", F_WAIT, 16'd2);
    tick(); expect_out("div5_T3", F_WAIT, 16'd3);
    tick(); idle_inputs(); expect_out("div5_done", F_DONE, 16'd4);

    // Saturation of stall_count
    tick(); set_hazard_a();
    repeat (70000) tick();
    expect_out("saturate", F_STALL, 16'hFFFF);
    tick(); idle_inputs(); expect_out("saturate_hold", F_NONE, 16'hFFFF);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout: elapsed=%0t limit=1000000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
